// File: rtl/seq_pattern_pkg.sv
// Shared types and helpers for the serial pattern detector.
package seq_pattern_pkg;

  localparam int unsigned STATE_W    = 2;
  localparam int unsigned MASK_MAX_W = 64;

  typedef enum logic [STATE_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_ARMED = 2'd2
  } state_e;

  // Low `len` bits set; callers truncate to their own pattern width.
  function automatic logic [MASK_MAX_W-1:0] len_mask(input int unsigned len);
    logic [MASK_MAX_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_MAX_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment yields 1.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? W'(1) : '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with runtime pattern/length/mode and a
// saturating hit counter.
module seq_pattern_detector
  import seq_pattern_pkg::*;
#(
  parameter int unsigned          MAX_LEN         = 16,
  parameter int unsigned          LEN_W           = $clog2(MAX_LEN + 1),
  parameter int unsigned          CNT_W           = 8,
  parameter logic [MAX_LEN-1:0]   DEFAULT_PATTERN = MAX_LEN'(4'b1011),
  parameter int unsigned          DEFAULT_LEN     = 4,
  parameter bit                   DEFAULT_OVERLAP = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [MAX_LEN-1:0]  cfg_pattern,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic                cfg_overlap,
  input  logic                cnt_clr,
  input  logic                din_valid,
  input  logic                datain,
  output logic                hit,
  output logic [CNT_W-1:0]    hit_count,
  output logic                cfg_err,
  output logic [STATE_W-1:0]  state
);

  localparam logic [LEN_W-1:0] RST_LEN   = LEN_W'(DEFAULT_LEN);
  localparam state_e           RST_STATE = (DEFAULT_LEN <= 1) ? ST_ARMED : ST_EMPTY;

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               hit_q, hit_d;
  logic               err_q, err_d;
  state_e             state_q, state_d;

  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] shifted;
  logic               cfg_ok;
  logic               match;

  always_comb begin
    mask    = MAX_LEN'(len_mask(int'(len_q)));
    shifted = (hist_q << 1) | MAX_LEN'(datain);
    cfg_ok  = cfg_we && (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    // A legal config load swallows the data bit, so it can never match.
    match   = din_valid && !cfg_ok
              && (fill_q >= (len_q - LEN_W'(1)))
              && ((shifted & mask) == (pat_q & mask));
  end

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    hit_d  = 1'b0;
    err_d  = cfg_we && !cfg_ok;

    if (cfg_ok) begin
      pat_d  = cfg_pattern;
      len_d  = cfg_len;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (din_valid) begin
      hist_d = shifted;
      hit_d  = match;
      if (match && !ovl_q) begin
        fill_d = '0;
      end else if (fill_q < len_q) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end

    if (fill_d >= (len_d - LEN_W'(1))) state_d = ST_ARMED;
    else if (fill_d == '0)             state_d = ST_EMPTY;
    else                               state_d = ST_FILL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= DEFAULT_PATTERN;
      len_q   <= RST_LEN;
      ovl_q   <= DEFAULT_OVERLAP;
      hist_q  <= '0;
      fill_q  <= '0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
      state_q <= RST_STATE;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .inc_i (match),
    .cnt_o (hit_count)
  );

  assign hit     = hit_q;
  assign cfg_err = err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed self-checking bench for seq_pattern_detector (8-bit and 2-bit counters).
module tb_seq_pattern_detector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_pattern = '0;
  logic [4:0]  cfg_len = '0;
  logic        cfg_overlap = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        din_valid = 1'b0;
  logic        datain = 1'b0;

  logic        hit, hit2, cfg_err, cfg_err2;
  logic [7:0]  hit_count;
  logic [1:0]  hit_count2;
  logic [1:0]  state, state2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_pattern_detector #(.MAX_LEN(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .din_valid(din_valid), .datain(datain), .hit(hit),
    .hit_count(hit_count), .cfg_err(cfg_err), .state(state)
  );

  seq_pattern_detector #(.MAX_LEN(16), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .din_valid(din_valid), .datain(datain), .hit(hit2),
    .hit_count(hit_count2), .cfg_err(cfg_err2), .state(state2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic we, input logic [15:0] p,
                      input logic [4:0] l, input logic o, input logic clr,
                      input logic dv, input logic d);
    @(negedge clk);
    rst = r; cfg_we = we; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    cnt_clr = clr; din_valid = dv; datain = d;
    @(posedge clk);
    #1;
  endtask

  task automatic vchk(input string tag, input logic dv, input logic d,
                      input logic eh, input logic [1:0] es);
    step(1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, dv, d);
    chk({tag, "_hit"}, hit, eh);
    chk({tag, "_state"}, state, es);
  endtask

  // Bit n-1 of each vector is the first applied.
  task automatic stream(input string tag, input int n, input logic [15:0] bits,
                        input logic [15:0] hits, input logic [31:0] sts);
    for (int i = n - 1; i >= 0; i--) begin
      vchk($sformatf("%s_b%0d", tag, n - i), 1'b1, bits[i], hits[i], sts[2*i +: 2]);
    end
  endtask

  initial begin
    // Reset
    step(1'b1, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rst_hit", hit, 0);
    chk("rst_cnt", hit_count, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_state", state, 0);

    // 1: defaults, overlapping
    stream("t1", 7, 16'b1011011, 16'b0001001,
           {2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2});
    chk("t1_cnt", hit_count, 2);
    chk("t1_cnt2", hit_count2, 2);

    // 2: non-overlapping
    step(1'b0, 1'b1, 16'h000B, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_cfg_state", state, 0);
    chk("t2_cfg_err", cfg_err, 0);
    chk("t2_cfg_cnt", hit_count, 2);
    stream("t2", 7, 16'b1011011, 16'b0001000,
           {2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2});
    chk("t2_cnt", hit_count, 3);

    // 3: gaps between valid bits
    step(1'b0, 1'b1, 16'h000B, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    vchk("t3_v1", 1'b1, 1'b1, 1'b0, 2'd1);
    vchk("t3_g1", 1'b0, 1'b0, 1'b0, 2'd1);
    vchk("t3_v2", 1'b1, 1'b0, 1'b0, 2'd1);
    vchk("t3_g2", 1'b0, 1'b1, 1'b0, 2'd1);
    vchk("t3_v3", 1'b1, 1'b1, 1'b0, 2'd2);
    vchk("t3_g3", 1'b0, 1'b0, 1'b0, 2'd2);
    vchk("t3_v4", 1'b1, 1'b1, 1'b1, 2'd2);
    vchk("t3_g4", 1'b0, 1'b0, 1'b0, 2'd2);
    chk("t3_cnt", hit_count, 4);

    // 4: illegal lengths rejected, then len 1
    step(1'b0, 1'b1, 16'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_err0", cfg_err, 1);
    chk("t4_err0_state", state, 2);
    step(1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_err_pulse", cfg_err, 0);
    step(1'b0, 1'b1, 16'h0000, 5'd17, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_err17", cfg_err, 1);
    chk("t4_err17_state", state, 2);
    stream("t4a", 4, 16'b1011, 16'b0001, {2'd2, 2'd2, 2'd2, 2'd2});
    chk("t4a_cnt", hit_count, 5);
    step(1'b0, 1'b1, 16'hA5A5, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_len1_state", state, 2);
    chk("t4_len1_err", cfg_err, 0);
    stream("t4b", 4, 16'b1101, 16'b1101, {2'd2, 2'd2, 2'd2, 2'd2});
    chk("t4b_cnt", hit_count, 8);
    step(1'b0, 1'b1, 16'h0000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t4_badcfg_dv_hit", hit, 1);
    chk("t4_badcfg_dv_err", cfg_err, 1);
    chk("t4_badcfg_dv_cnt", hit_count, 9);
    step(1'b0, 1'b1, 16'h0001, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t4_cfg_dv_hit", hit, 0);
    chk("t4_cfg_dv_err", cfg_err, 0);
    chk("t4_cfg_dv_cnt", hit_count, 9);
    chk("t4_cnt2_sat", hit_count2, 3);

    // 5: counter saturation and clear
    step(1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_clr_cnt", hit_count, 0);
    chk("t5_clr_cnt2", hit_count2, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk($sformatf("t5_cnt_%0d", i), hit_count, i + 1);
      chk($sformatf("t5_cnt2_%0d", i), hit_count2, (i < 3) ? i + 1 : 3);
    end
    step(1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5_clrinc_hit", hit, 1);
    chk("t5_clrinc_cnt", hit_count, 1);
    chk("t5_clrinc_cnt2", hit_count2, 1);

    // 6: reset mid-pattern restores defaults
    step(1'b0, 1'b1, 16'h000B, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    stream("t6a", 3, 16'b101, 16'b000, {2'd1, 2'd1, 2'd2});
    step(1'b1, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t6_rst_hit", hit, 0);
    chk("t6_rst_cnt", hit_count, 0);
    chk("t6_rst_cnt2", hit_count2, 0);
    chk("t6_rst_state", state, 0);
    chk("t6_rst_err", cfg_err, 0);
    stream("t6b", 5, 16'b11011, 16'b00001, {2'd1, 2'd1, 2'd2, 2'd2, 2'd2});
    stream("t6c", 3, 16'b011, 16'b001, {2'd2, 2'd2, 2'd2});
    chk("t6_cnt", hit_count, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
Parametrised serial bit-pattern detector, successor to the fixed-sequence one-hot pattern_identifier. It watches a qualified serial stream on datain and pulses hit when the last LEN accepted bits equal a runtime-programmable pattern. Overlapping and non-overlapping modes are supported, and a saturating hit counter is included. It sits between a serial front-end and status/interrupt logic.

Parameters:
MAX_LEN, 16, maximum pattern length in bits (>=1)
LEN_W, $clog2(MAX_LEN+1), width of length fields (derived, do not override)
CNT_W, 8, hit counter width
DEFAULT_PATTERN, 16'b1011, pattern after reset (MAX_LEN bits, right-aligned)
DEFAULT_LEN, 4, pattern length after reset
DEFAULT_OVERLAP, 1, mode after reset (1 = overlapping)

Ports:
clk  in  1  single clock; all logic is rising-edge
rst  in  1  synchronous, active-high reset
cfg_we  in  1  load configuration this cycle
cfg_pattern  in  MAX_LEN  new pattern, right-aligned; bit [len-1] is the first-received bit, bit [0] is the last
cfg_len  in  LEN_W  new length; legal range 1..MAX_LEN
cfg_overlap  in  1  new mode
cnt_clr  in  1  clear hit_count
din_valid  in  1  datain is a valid bit this cycle
datain  in  1  serial data
hit  out  1  one-cycle match pulse
hit_count  out  CNT_W  saturating number of hits
cfg_err  out  1  one-cycle pulse: illegal cfg_len was rejected
state  out  2  detector state: EMPTY=0, FILL=1, ARMED=2

Behaviour:
- Reset (rst=1 at an edge):
  - hit=0, cfg_err=0, hit_count=0, state=EMPTY.
  - History and fill count cleared.
  - Active pattern, length and mode set to their DEFAULT_* values.
  - rst overrides every other input.
- Registered config: active pattern (pat), length (len) and overlap mode (ovl) are registers.
  - mask = low len bits set.
- Shift and fill:
  - Only cycles with din_valid=1 shift the history: hist <= {hist, datain}.
  - fill counts accepted bits and saturates at len.
  - din_valid=0: history, fill, state hold; hit=0.
- Match: a match is detected in a cycle when all of the following hold:
  - din_valid=1;
  - fill >= len-1;
  - ({hist,datain} & mask) == (pat & mask).
- Latency: hit is registered. It is 1 in the cycle after the edge that samples the final pattern bit, for exactly one cycle per match.
- Overlap mode (ovl=1): history is kept after a match, so matches may share bits.
- Non-overlap mode (ovl=0): on a match, fill is cleared to 0. The next match needs len fresh bits.
- State encoding, derived from fill after the update:
  - EMPTY: fill=0.
  - FILL: 0 < fill < len-1.
  - ARMED: fill >= len-1 (the next valid bit can complete a match).
  - With len=1, the detector is always ARMED after reset or config.
- Config load (cfg_we=1):
  - If cfg_len is in 1..MAX_LEN: load pat/len/ovl, clear history and fill, go to EMPTY (ARMED if len=1), force hit=0 next cycle.
  - Otherwise: config is unchanged, history is untouched, and cfg_err pulses for one cycle.
  - A legal config and din_valid in the same cycle: config wins and the data bit is discarded.
  - An illegal config and din_valid in the same cycle: the data bit is processed normally.
- Counter:
  - hit_count increments on each match and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr sets it to 0.
  - cnt_clr and a match in the same cycle: hit_count=1.
  - A config load does not clear hit_count.
- Bits of cfg_pattern above cfg_len are don't-care; they are masked on compare.

Decomposition:
- Shared package seq_pattern_pkg holds:
  - state encodings ST_EMPTY/ST_FILL/ST_ARMED and the state width (2);
  - a function computing mask from len.
- One natural sub-module: sat_counter, a parametrised width with inc, clr, clr-then-inc priority and saturation. It is reused for hit_count.
- Shift/match/fill logic stays in the top module.

Test Plan:
1. Defaults (1011, len 4, overlap). Stream 1,0,1,1,0,1,1 with din_valid=1 -> hit pulses the cycle after bit 4 and after bit 7; hit_count=2.
2. Same stream after loading cfg_overlap=0, len 4, 1011 -> single hit after bit 4; hit_count increments by 1; state returns to EMPTY after the match.
3. Stream 1,0,1,1 with din_valid=0 inserted between every bit (datain toggled during gaps) -> exactly one hit, one cycle after the final valid bit; gap values ignored.
4. cfg_len=0, then cfg_len=17 (MAX_LEN=16) -> cfg_err pulses each time; pattern/len unchanged, proven by stream 1011 still hitting. Then cfg_len=1, pattern 1; stream 1,1,0,1 -> hits after bits 1, 2 and 4.
5. CNT_W=2, len 1, pattern 1, five consecutive valid 1s -> hit_count 1,2,3,3,3. Then cnt_clr with a simultaneous match -> hit_count=1.
6. rst=1 after 1,0,1 of 1011 (state ARMED) -> next cycle: hit=0, hit_count=0, state=EMPTY, defaults restored. Then a single 1 gives no hit; a full 1011 gives one hit.
